// File: rtl/key_recognition_multi.sv
// key_recognition_multi
//   Multi-channel key recogniser for a bank of raw active-low push-buttons.
//   Each channel is synchronised, debounced, and tracked for press, long
//   press, auto-repeat and release. Every flag is a registered 1-cycle pulse.
//
// Parameters
//   N_KEYS        number of independent key channels
//   DEBOUNCE      consecutive stable samples to accept a press or a release
//   LONG_PRESS    held cycles after flag_press before flag_long
//   REPEAT_PERIOD cycles between successive flag_repeat pulses
//   REPEAT_EN     1 = auto-repeat after a long press, 0 = never repeat
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   key_N        raw asynchronous keys, 0 = pressed
//   key_level    debounced key state, 1 = pressed
//   flag_press   pulse on accepted press
//   flag_long    pulse when the long-press threshold is reached
//   flag_repeat  pulse per repeat period after a long press
//   flag_release pulse on accepted release
module key_recognition_multi #(
  parameter int N_KEYS        = 4,
  parameter int DEBOUNCE      = 20,
  parameter int LONG_PRESS    = 1000,
  parameter int REPEAT_PERIOD = 200,
  parameter int REPEAT_EN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_N,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] flag_press,
  output logic [N_KEYS-1:0] flag_long,
  output logic [N_KEYS-1:0] flag_repeat,
  output logic [N_KEYS-1:0] flag_release
);

  localparam int HOLD_MAX = (LONG_PRESS > REPEAT_PERIOD) ? LONG_PRESS : REPEAT_PERIOD;
  localparam int DW       = $clog2(DEBOUNCE + 1);
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_PERIOD - 1);
  localparam logic          REPEAT_ON = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic          sync1, sync2, k;
    state_t        state_q, state_d;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          rel_q, rel_d;

    // Synchroniser resets to "released" so a held key after reset is seen
    // as a fresh press.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_N[i];
        sync2 <= sync1;
      end
    end

    assign k = ~sync2;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q     <= IDLE;
        db_q        <= '0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        long_q      <= 1'b0;
        rep_q       <= 1'b0;
        rel_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        db_q        <= db_d;
        hold_q      <= hold_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        long_q      <= long_d;
        rep_q       <= rep_d;
        rel_q       <= rel_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      db_d        = db_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      long_d      = 1'b0;
      rep_d       = 1'b0;
      rel_d       = 1'b0;

      case (state_q)
        IDLE: begin
          if (k) begin
            state_d = PRESS_DB;
            db_d    = DW'(1);
          end
        end

        PRESS_DB: begin
          if (!k) begin
            state_d = IDLE;
            db_d    = '0;
          end else if (db_q >= DB_LAST) begin
            // >= so that DEBOUNCE=1 still spends exactly one sample here
            state_d     = HELD;
            db_d        = '0;
            press_d     = 1'b1;
            level_d     = 1'b1;
            hold_d      = '0;
            long_done_d = 1'b0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end

        HELD: begin
          if (k) begin
            // hold_q counts completed held cycles; the flag fires on the
            // edge where the incremented count would reach the threshold.
            if (!long_done_q) begin
              if (hold_q >= LONG_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
                hold_d      = '0;
              end else begin
                hold_d = hold_q + 1'b1;
              end
            end else if (REPEAT_ON) begin
              if (hold_q >= REP_LAST) begin
                rep_d  = 1'b1;
                hold_d = '0;
              end else begin
                hold_d = hold_q + 1'b1;
              end
            end else begin
              hold_d = '0;
            end
          end else begin
            state_d = REL_DB;
            db_d    = DW'(1);
          end
        end

        REL_DB: begin
          if (k) begin
            // bounce: resume holding with hold progress preserved
            state_d = HELD;
            db_d    = '0;
          end else if (db_q >= DB_LAST) begin
            state_d = IDLE;
            db_d    = '0;
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    assign key_level[i]    = level_q;
    assign flag_press[i]   = press_q;
    assign flag_long[i]    = long_q;
    assign flag_repeat[i]  = rep_q;
    assign flag_release[i] = rel_q;
  end

endmodule

// File: doc/key_recognition_multi.md
# key_recognition_multi

Multi-channel, parametrised key recogniser. It synchronises and debounces N_KEYS raw active-low buttons and, per channel, emits single-cycle press, long-press, auto-repeat and release flags plus a debounced level. It sits between the board push-buttons and the clock-setting control FSM. It replaces per-key single-press recognisers so that one instance serves the whole key bank with long-hold and auto-increment support.

## Interface
- N_KEYS, 4: number of independent key channels (≥1)
- DEBOUNCE, 20: consecutive stable samples required to accept a press or a release (≥1)
- LONG_PRESS, 1000: held cycles after flag_press before flag_long (≥1)
- REPEAT_PERIOD, 200: cycles between successive flag_repeat pulses (≥1)
- REPEAT_EN, 1: 1 = auto-repeat after long press; 0 = no flag_repeat ever
- Counter widths are localparams derived via $clog2 from the above; there are no width parameters.

Ports:
- clk  in  1  system clock (1 kHz tick in the clock design; the block is rate-agnostic)
- rst  in  1  reset; one clock; reset is synchronous and active-high
- key_N  in  N_KEYS  raw asynchronous keys, 0 = pressed
- key_level  out  N_KEYS  debounced key state, 1 = pressed
- flag_press  out  N_KEYS  1-cycle pulse on accepted press
- flag_long  out  N_KEYS  1-cycle pulse on long-press threshold
- flag_repeat  out  N_KEYS  1-cycle pulse per repeat period
- flag_release  out  N_KEYS  1-cycle pulse on accepted release

## Operation
- Each channel is fully independent: 2-flop synchroniser on key_N[i]; k = ~sync2.
- Per-channel FSM states: IDLE, PRESS_DB, HELD, REL_DB. Per-channel registers: db_cnt, hold_cnt and long_done.
- IDLE: when k=1, go to PRESS_DB with db_cnt=1.
- PRESS_DB: when k=0, go to IDLE with db_cnt=0. When k=1 and db_cnt=DEBOUNCE-1, go to HELD and register flag_press=1, key_level=1, hold_cnt=0, long_done=0. Otherwise increment db_cnt.
- HELD with k=1: increment hold_cnt.
  - long_done=0 and hold_cnt reaches LONG_PRESS: flag_long=1, long_done=1, hold_cnt=0.
  - long_done=1, REPEAT_EN=1 and hold_cnt reaches REPEAT_PERIOD: flag_repeat=1, hold_cnt=0.
  - long_done=1, REPEAT_EN=0: hold_cnt holds at 0.
- HELD with k=0: go to REL_DB with db_cnt=1. hold_cnt does not advance.
- REL_DB:
  - k=1 (bounce): return to HELD with db_cnt=0. hold_cnt and long_done are kept, and hold_cnt does not advance on this edge.
  - k=0 and db_cnt=DEBOUNCE-1: flag_release=1, key_level=0, go to IDLE.
  - Otherwise increment db_cnt.
- hold_cnt increments only on edges where the state is HELD and k=1. A release bounce of n low samples therefore delays the next long/repeat flag by n+1 cycles.
- flag_long and flag_repeat never fire in the same cycle on one channel. Different channels may flag in the same cycle.
- With DEBOUNCE=1, PRESS_DB still lasts exactly one sample.

## Timing
- Reset: all outputs 0. Sync flops are set to 1 (released), state is IDLE, and all counters and long_done are 0. Reset takes priority over every other event.
- Press latency: flag_press and the rise of key_level occur in the cycle after the (DEBOUNCE+2)-th rising edge. Edges are counted from the first edge that samples key_N[i]=0 (2 synchroniser edges + DEBOUNCE samples).
- Release latency: flag_release and the fall of key_level occur in the cycle after the (DEBOUNCE+2)-th edge. Edges are counted from the first edge that samples key_N[i]=1.
- Without bounces:
  - flag_long occurs exactly LONG_PRESS cycles after the flag_press cycle.
  - The k-th flag_repeat occurs LONG_PRESS + k·REPEAT_PERIOD cycles after flag_press.
- All flags are registered and last exactly one cycle. key_level is registered.
- Reset mid-hold: after rst deasserts, a still-held key is a new press. It needs full debounce and produces a fresh flag_press, with no flag_release for the aborted press.
- A key released before flag_long produces no flag_long. A release during the repeat phase produces no further flag_repeat.

## Test plan
Configuration: N_KEYS=2, DEBOUNCE=20, LONG_PRESS=100, REPEAT_PERIOD=30, REPEAT_EN=1 unless stated.
- Clean tap: key_N[0] low for 60 cycles, then high.
  - flag_press on edge 22 from the first low sample.
  - flag_release 22 edges after the first high sample.
  - key_level[0] high between them; no long or repeat flags.
- Press bounce: 10 cycles low, 3 high, 10 low, then high. No flags and key_level stays 0. A following steady 25-cycle low produces flag_press at edge 22 of that run.
- Long hold of 250 cycles: flag_long at +100 after flag_press, then flag_repeat at +130, +160, +190, +220. With REPEAT_EN=0 the same stimulus gives flag_long only.
- Release bounce mid-hold at +50: 5 high samples, then low again. No flag_release; key_level stays 1; flag_long moves to +106.
- Reset mid-hold: rst high for 2 cycles at +40 while the key is held.
  - All outputs 0 after the reset edge.
  - flag_press again 22 edges after the first post-reset sample.
  - No flag_release for the aborted press.
- Two channels: key0 and key1 pressed on the same edge, key1 released 10 cycles earlier. Both flag_press fire in the same cycle; release flags are independent and correctly spaced.
